// File: rtl/alu_result_monitor.sv
// alu_result_monitor
//   Passive monitor on the TinyALU pin interface. Follows the start/op/A/B/done/result
//   handshake, builds one record per operation (op, operands, result, latency, timeout)
//   and queues it in a small FIFO that is drained over a valid/ready port.
// Ports
//   clk, reset          clock and synchronous active-high reset
//   start, op, A, B     driver-side request
//   done, result        ALU completion strobe and result
//   rec_valid/rec_ready record handshake; rec_* carry the FIFO head (0 when empty)
//   drop_cnt            records lost to a full FIFO, saturating
//   protocol_err        sticky handshake-violation flag
module alu_result_monitor #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LAT_W      = 5,
  parameter int unsigned TIMEOUT    = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             done,
  input  logic [15:0]      result,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [2:0]       rec_op,
  output logic [7:0]       rec_A,
  output logic [7:0]       rec_B,
  output logic [15:0]      rec_result,
  output logic [LAT_W-1:0] rec_latency,
  output logic             rec_timeout,
  output logic [7:0]       drop_cnt,
  output logic             protocol_err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [LAT_W-1:0] TimeoutLat = LAT_W'(TIMEOUT);
  localparam logic [PtrW:0]    FullCnt    = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StWaitLow} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [LAT_W-1:0] lat_q, lat_d, lat_inc;
  logic             perr_q, perr_d;

  // Record presented to the FIFO this cycle
  logic             push;
  logic [2:0]       push_op;
  logic [7:0]       push_a, push_b;
  logic [15:0]      push_res;
  logic [LAT_W-1:0] push_lat;
  logic             push_to;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    lat_d    = lat_q;
    perr_d   = perr_q;
    lat_inc  = lat_q + LAT_W'(1);
    push     = 1'b0;
    push_op  = op_q;
    push_a   = a_q;
    push_b   = b_q;
    push_res = '0;
    push_lat = '0;
    push_to  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (op != 3'b000) begin
            op_d    = op;
            a_d     = A;
            b_d     = B;
            lat_d   = '0;
            state_d = StBusy;
          end else begin
            // no_op completes at capture: zero result and latency
            push    = 1'b1;
            push_op = op;
            push_a  = A;
            push_b  = B;
            state_d = StWaitLow;
          end
        end else if (done) begin
          perr_d = 1'b1;
        end
      end
      StBusy: begin
        lat_d = lat_inc;
        if (done) begin
          push     = 1'b1;
          push_res = result;
          push_lat = lat_inc;
          state_d  = StWaitLow;
        end else if (lat_inc == TimeoutLat) begin
          push     = 1'b1;
          push_lat = TimeoutLat;
          push_to  = 1'b1;
          state_d  = StWaitLow;
        end
        // start dropped early, or request changed while still asserted
        if (!start && !done) perr_d = 1'b1;
        if (start && ((op != op_q) || (A != a_q) || (B != b_q))) perr_d = 1'b1;
      end
      StWaitLow: begin
        if (!start) state_d = StIdle;
        if (done) perr_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lat_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lat_q   <= lat_d;
      perr_q  <= perr_d;
    end
  end

  // Record FIFO
  logic [2:0]       mem_op  [FIFO_DEPTH];
  logic [7:0]       mem_a   [FIFO_DEPTH];
  logic [7:0]       mem_b   [FIFO_DEPTH];
  logic [15:0]      mem_res [FIFO_DEPTH];
  logic [LAT_W-1:0] mem_lat [FIFO_DEPTH];
  logic             mem_to  [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;
  logic [7:0]      drop_q;
  logic            empty, full, pop, wr_en, drop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FullCnt);
  assign pop   = !empty && rec_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_op[wr_ptr_q]  <= push_op;
      mem_a[wr_ptr_q]   <= push_a;
      mem_b[wr_ptr_q]   <= push_b;
      mem_res[wr_ptr_q] <= push_res;
      mem_lat[wr_ptr_q] <= push_lat;
      mem_to[wr_ptr_q]  <= push_to;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + (PtrW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows
  always_comb begin
    rec_valid   = !empty;
    rec_op      = '0;
    rec_A       = '0;
    rec_B       = '0;
    rec_result  = '0;
    rec_latency = '0;
    rec_timeout = 1'b0;
    if (!empty) begin
      rec_op      = mem_op[rd_ptr_q];
      rec_A       = mem_a[rd_ptr_q];
      rec_B       = mem_b[rd_ptr_q];
      rec_result  = mem_res[rd_ptr_q];
      rec_latency = mem_lat[rd_ptr_q];
      rec_timeout = mem_to[rd_ptr_q];
    end
  end

  assign drop_cnt     = drop_q;
  assign protocol_err = perr_q;

endmodule
